// File: rtl/idex_cond_unit.sv
// ---------------------------------------------------------------------------
// idex_cond_unit
// ID/EX pipeline register for an ARM-style core, with condition evaluation,
// condition-gated control outputs and the NZCV flags register.
//
// Optional feature macro: COND_EXEC_EN
//   defined     - CondExE is decoded from the registered condition field
//                 and the current flags.
//   not defined - CondExE is tied to 1 and the condition field is ignored.
// ---------------------------------------------------------------------------
module idex_cond_unit #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       PCSrcD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       MemWriteD,
    input  logic       BranchD,
    input  logic       ALUSrcD,
    input  logic       NoWriteD,
    input  logic [2:0] ALUControlD,
    input  logic [1:0] FlagWriteD,
    input  logic [3:0] CondD,
    input  logic [3:0] ALUFlags,
    output logic       MemtoRegE,
    output logic       ALUSrcE,
    output logic [2:0] ALUControlE,
    output logic       PCSrcGE,
    output logic       RegWriteGE,
    output logic       MemWriteGE,
    output logic       BranchTakenE,
    output logic       CondExE,
    output logic [3:0] FlagsE
);

    // Everything the decode stage hands to the execute stage.
    typedef struct packed {
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       no_write;
        logic [2:0] alu_control;
        logic [1:0] flag_write;
        logic [3:0] cond;
    } e_ctrl_t;

    e_ctrl_t    e_ctrl_d, e_ctrl_q;
    logic [3:0] flags_d, flags_q;

    // Next E-stage contents: bubble on flush (wins over stall), hold on stall,
    // otherwise capture the decode-stage control.
    // NOTE: every always_comb output gets a default first, so no latch can form.
    always_comb begin
        e_ctrl_d = e_ctrl_q;
        if (FlushE) begin
            e_ctrl_d = '0;
        end else if (!StallE) begin
            e_ctrl_d.pc_src      = PCSrcD;
            e_ctrl_d.reg_write   = RegWriteD;
            e_ctrl_d.mem_to_reg  = MemtoRegD;
            e_ctrl_d.mem_write   = MemWriteD;
            e_ctrl_d.branch      = BranchD;
            e_ctrl_d.alu_src     = ALUSrcD;
            e_ctrl_d.no_write    = NoWriteD;
            e_ctrl_d.alu_control = ALUControlD;
            e_ctrl_d.flag_write  = FlagWriteD;
            e_ctrl_d.cond        = CondD;
        end
    end

`ifdef COND_EXEC_EN
    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Decode the E-stage condition field against the current NZCV flags.
    always_comb begin
        CondExE = 1'b0;
        case (e_ctrl_q.cond)
            4'b0000: CondExE = flag_z;                                // EQ
            4'b0001: CondExE = !flag_z;                               // NE
            4'b0010: CondExE = flag_c;                                // CS
            4'b0011: CondExE = !flag_c;                               // CC
            4'b0100: CondExE = flag_n;                                // MI
            4'b0101: CondExE = !flag_n;                               // PL
            4'b0110: CondExE = flag_v;                                // VS
            4'b0111: CondExE = !flag_v;                               // VC
            4'b1000: CondExE = flag_c && !flag_z;                     // HI
            4'b1001: CondExE = !flag_c || flag_z;                     // LS
            4'b1010: CondExE = (flag_n == flag_v);                    // GE
            4'b1011: CondExE = (flag_n != flag_v);                    // LT
            4'b1100: CondExE = !flag_z && (flag_n == flag_v);         // GT
            4'b1101: CondExE = flag_z || (flag_n != flag_v);          // LE
            4'b1110: CondExE = 1'b1;                                  // AL
            default: CondExE = 1'b0;                                  // 1111: never
        endcase
    end
`else
    // Every instruction executes; the condition field is carried but unused.
    logic unused_cond;
    assign unused_cond = ^e_ctrl_q.cond;
    assign CondExE     = 1'b1;
`endif

    // Flags update from the instruction leaving E; a stall freezes the flags,
    // a flush does not (it only affects what enters E).
    always_comb begin
        flags_d = flags_q;
        if (!StallE && CondExE) begin
            if (e_ctrl_q.flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
            if (e_ctrl_q.flag_write[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // E-stage control and flags registers with asynchronous reset.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_ctrl_q <= '0;
            flags_q  <= FLAGS_RST;
        end else begin
            e_ctrl_q <= e_ctrl_d;
            flags_q  <= flags_d;
        end
    end

    // Ungated registered control and the flags register.
    assign MemtoRegE    = e_ctrl_q.mem_to_reg;
    assign ALUSrcE      = e_ctrl_q.alu_src;
    assign ALUControlE  = e_ctrl_q.alu_control;
    assign FlagsE       = flags_q;

    // Condition-gated control; compare-type instructions never write the RF.
    assign PCSrcGE      = e_ctrl_q.pc_src    & CondExE;
    assign MemWriteGE   = e_ctrl_q.mem_write & CondExE;
    assign BranchTakenE = e_ctrl_q.branch    & CondExE;
    assign RegWriteGE   = e_ctrl_q.reg_write & CondExE & ~e_ctrl_q.no_write;

endmodule

// File: tb/tb_idex_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_idex_cond_unit
// Self-checking bench for idex_cond_unit: directed scenarios plus randomized
// traffic checked against an instruction-level reference model.
// Honours COND_EXEC_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_idex_cond_unit;

    localparam logic [3:0] FLAGS_RST = 4'b0000;
    localparam logic [3:0] C_AL      = 4'b1110;
`ifdef COND_EXEC_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       no_write;
        logic [2:0] alu_control;
        logic [1:0] flag_write;
        logic [3:0] cond;
    } instr_t;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       flush;
    logic [3:0] alu_flags;
    instr_t     d;

    logic       MemtoRegE, ALUSrcE, PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE, CondExE;
    logic [2:0] ALUControlE;
    logic [3:0] FlagsE;
    logic [13:0] obs;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the instruction currently in E and the flags register.
    instr_t     m_e;
    logic [3:0] m_flags;

    idex_cond_unit #(.FLAGS_RST(FLAGS_RST)) dut (
        .clk         (clk),
        .reset       (reset),
        .StallE      (stall),
        .FlushE      (flush),
        .PCSrcD      (d.pc_src),
        .RegWriteD   (d.reg_write),
        .MemtoRegD   (d.mem_to_reg),
        .MemWriteD   (d.mem_write),
        .BranchD     (d.branch),
        .ALUSrcD     (d.alu_src),
        .NoWriteD    (d.no_write),
        .ALUControlD (d.alu_control),
        .FlagWriteD  (d.flag_write),
        .CondD       (d.cond),
        .ALUFlags    (alu_flags),
        .MemtoRegE   (MemtoRegE),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .PCSrcGE     (PCSrcGE),
        .RegWriteGE  (RegWriteGE),
        .MemWriteGE  (MemWriteGE),
        .BranchTakenE(BranchTakenE),
        .CondExE     (CondExE),
        .FlagsE      (FlagsE)
    );

    assign obs = {MemtoRegE, ALUSrcE, ALUControlE, PCSrcGE, RegWriteGE,
                  MemWriteGE, BranchTakenE, CondExE, FlagsE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural condition check: bits [3:1] pick a predicate, bit 0 inverts it.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        if (!COND_EN) return 1'b1;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'b1111) return 1'b0;
        if (c == 4'b1110) return 1'b1;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [13:0] exp_out();
        bit ce;
        ce = cond_ok(m_e.cond, m_flags);
        return {m_e.mem_to_reg, m_e.alu_src, m_e.alu_control,
                m_e.pc_src & ce, m_e.reg_write & ce & ~m_e.no_write,
                m_e.mem_write & ce, m_e.branch & ce, ce, m_flags};
    endfunction

    // Advance one clock: predict the next model state from the current inputs,
    // then sample the DUT 1 time unit after the edge.
    task automatic step();
        instr_t     nx_e;
        logic [3:0] nx_f;
        bit         ce;
        ce   = cond_ok(m_e.cond, m_flags);
        nx_f = m_flags;
        if (!stall && ce) begin
            if (m_e.flag_write[1]) nx_f[3:2] = alu_flags[3:2];
            if (m_e.flag_write[0]) nx_f[1:0] = alu_flags[1:0];
        end
        nx_e = flush ? instr_t'(0) : (stall ? m_e : d);
        if (reset) begin
            nx_e = '0;
            nx_f = FLAGS_RST;
        end
        @(posedge clk);
        m_e     = nx_e;
        m_flags = nx_f;
        #1;
    endtask

    // A flag-setting compare (writes NZCV, never the register file).
    task automatic load_cmp();
        d = '0;
        d.flag_write = 2'b11;
        d.no_write   = 1'b1;
        d.reg_write  = 1'b1;
        d.cond       = C_AL;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; alu_flags = 4'b0000; d = '0;
        m_e = '0; m_flags = FLAGS_RST;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== exp_out()) $display("FAIL reset_state: got %b expected %b", obs, exp_out());
        else n_pass++;
        reset = 1'b0;
        d = '0; d.reg_write = 1'b1; d.cond = C_AL;
        step();
        n_checks++;
        if (RegWriteGE !== 1'b1 || obs !== exp_out())
            $display("FAIL reset_first_capture: got %b expected %b", obs, exp_out());
        else n_pass++;
        // Assert reset between edges: outputs must clear without a clock.
        #2 reset = 1'b1;
        #1;
        m_e = '0; m_flags = FLAGS_RST;
        n_checks++;
        if (RegWriteGE !== 1'b0 || FlagsE !== 4'b0000 || obs !== exp_out())
            $display("FAIL reset_async: got %b expected %b", obs, exp_out());
        else n_pass++;
        // Held in reset across an edge with live inputs.
        d = '1; alu_flags = 4'b1111;
        step();
        n_checks++;
        if (obs !== exp_out()) $display("FAIL reset_hold: got %b expected %b", obs, exp_out());
        else n_pass++;
        #2 reset = 1'b0;
        d = '0; d.alu_src = 1'b1; d.alu_control = 3'b101; d.cond = C_AL;
        step();
        n_checks++;
        if (ALUControlE !== 3'b101 || obs !== exp_out())
            $display("FAIL reset_resume: got %b expected %b", obs, exp_out());
        else n_pass++;
    endtask

    task automatic test_predicated_skip();
        bit exp_skip;
        exp_skip = COND_EN ? 1'b0 : 1'b1;
        load_cmp(); alu_flags = 4'b0100;
        step();
        d = '0; d.reg_write = 1'b1; d.mem_write = 1'b1; d.cond = 4'b0001;
        step();
        n_checks++;
        if ({CondExE, RegWriteGE, MemWriteGE} !== {3{exp_skip}} || obs !== exp_out())
            $display("FAIL predicated_skip: got %b expected %b", obs, exp_out());
        else n_pass++;
    endtask

    task automatic test_cmp_branch();
        load_cmp(); alu_flags = 4'b0100;
        step();
        n_checks++;
        if (RegWriteGE !== 1'b0 || CondExE !== 1'b1 || obs !== exp_out())
            $display("FAIL cmp_no_write: got %b expected %b", obs, exp_out());
        else n_pass++;
        d = '0; d.cond = 4'b0000; d.branch = 1'b1; d.pc_src = 1'b1;
        step();
        n_checks++;
        if (BranchTakenE !== 1'b1 || PCSrcGE !== 1'b1 || FlagsE !== 4'b0100 || obs !== exp_out())
            $display("FAIL cmp_branch_taken: got %b expected %b", obs, exp_out());
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        logic [3:0] held;
        logic [31:0] r;
        d = '0; d.alu_control = 3'b010; d.flag_write = 2'b11; d.cond = C_AL;
        alu_flags = 4'b1010;
        step();
        held = m_flags;
        stall = 1'b1; alu_flags = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            r = $urandom; d = r[15:0];
            step();
            n_checks++;
            if (ALUControlE !== 3'b010 || FlagsE !== held || obs !== exp_out())
                $display("FAIL stall_hold_%0d: got %b expected %b", i, obs, exp_out());
            else n_pass++;
        end
        flush = 1'b1;
        step();
        n_checks++;
        if ({MemtoRegE, ALUSrcE, ALUControlE, PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE} !== 9'b0
            || FlagsE !== held || obs !== exp_out())
            $display("FAIL stall_flush_bubble: got %b expected %b", obs, exp_out());
        else n_pass++;
        stall = 1'b0; flush = 1'b0;
        // A flush still lets the leaving instruction update the flags.
        load_cmp(); alu_flags = 4'b0011;
        step();
        flush = 1'b1; alu_flags = 4'b0110; d = '1;
        step();
        n_checks++;
        if (FlagsE !== 4'b0110 || ALUControlE !== 3'b000 || obs !== exp_out())
            $display("FAIL flush_flag_update: got %b expected %b", obs, exp_out());
        else n_pass++;
        flush = 1'b0;
    endtask

    task automatic test_partial_flag();
        load_cmp(); alu_flags = 4'b1111;
        step();
        d = '0; d.flag_write = 2'b10; d.cond = C_AL;
        step();
        d = '0; d.cond = C_AL; alu_flags = 4'b0000;
        step();
        n_checks++;
        if (FlagsE !== 4'b0011 || obs !== exp_out())
            $display("FAIL partial_flag_write: got %b expected %b", obs, exp_out());
        else n_pass++;
    endtask

    task automatic test_cond_decode();
        load_cmp(); alu_flags = 4'b1000;
        step();
        d = '0; d.reg_write = 1'b1; d.cond = 4'b1100;
        step();
        n_checks++;
        if (CondExE !== !COND_EN || obs !== exp_out())
            $display("FAIL cond_gt: got %b expected %b", obs, exp_out());
        else n_pass++;
        d.cond = 4'b1101;
        step();
        n_checks++;
        if (CondExE !== 1'b1 || obs !== exp_out())
            $display("FAIL cond_le: got %b expected %b", obs, exp_out());
        else n_pass++;
        d.cond = 4'b1111;
        step();
        n_checks++;
        if (CondExE !== !COND_EN || RegWriteGE !== !COND_EN || obs !== exp_out())
            $display("FAIL cond_never: got %b expected %b", obs, exp_out());
        else n_pass++;
    endtask

    // Every condition code against freshly written random flags.
    task automatic test_cond_sweep();
        logic [31:0] r;
        for (int c = 0; c < 16; c++) begin
            r = $urandom;
            load_cmp(); alu_flags = r[3:0];
            step();
            d = r[31:16]; d.cond = 4'(c); d.flag_write = 2'b00;
            step();
            n_checks++;
            if (obs !== exp_out())
                $display("FAIL cond_sweep_%0d: got %b expected %b", c, obs, exp_out());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            d = r[15:0];
            alu_flags = r[19:16];
            stall = (r[22:20] == 3'd0);
            flush = (r[25:23] == 3'd0);
            step();
            n_checks++;
            if (obs !== exp_out())
                $display("FAIL random_%0d: got %b expected %b", i, obs, exp_out());
            else n_pass++;
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_predicated_skip();
        test_cmp_branch();
        test_stall_flush();
        test_partial_flag();
        test_cond_decode();
        test_cond_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/idex_cond_unit.md
IDEX_COND_UNIT -- requirements
Module: idex_cond_unit

Interface
REQ-001 SHALL have parameter FLAGS_RST, default 4'b0000: reset value of the NZCV flags register.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port StallE, input, 1: hold all E-stage registers.
REQ-005 SHALL have port FlushE, input, 1: load a bubble into the E stage.
REQ-006 SHALL have ports PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD, input, 1 each: decoded control from the decode stage.
REQ-007 SHALL have ports ALUControlD, input, 3, and FlagWriteD, input, 2: decoded ALU op and flag-write enables ([1]=NZ, [0]=CV).
REQ-008 SHALL have port CondD, input, 4: instruction condition field Instr[31:28].
REQ-009 SHALL have port ALUFlags, input, 4: {N,Z,C,V} from the E-stage ALU.
REQ-010 SHALL have ports MemtoRegE, ALUSrcE, output, 1, and ALUControlE, output, 3: registered control, ungated.
REQ-011 SHALL have ports PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE, output, 1: condition-gated control.
REQ-012 SHALL have ports CondExE, output, 1, and FlagsE, output, 4: condition result and current flags register.

Function
REQ-013 SHALL register every D-stage input into an E-stage copy on each rising edge when StallE=0 and FlushE=0 (latency 1 cycle).
REQ-014 SHALL clear every E-stage control register, including CondE, to 0 on a clock edge with FlushE=1; flush has priority over a simultaneous StallE.
REQ-015 SHALL hold all E-stage registers and the flags register unchanged on a clock edge with StallE=1 and FlushE=0.
REQ-016 SHALL compute CondExE combinationally from CondE and FlagsE using these codes:
- EQ Z; NE !Z; CS C; CC !C
- MI N; PL !N; VS V; VC !V
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V
- GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 0
REQ-017 SHALL drive PCSrcGE=PCSrcE&CondExE, MemWriteGE=MemWriteE&CondExE, and BranchTakenE=BranchE&CondExE.
REQ-018 SHALL drive RegWriteGE=RegWriteE&CondExE&!NoWriteE.
REQ-019 SHALL load FlagsE[3:2] from ALUFlags[3:2] on a clock edge when FlagWriteE[1]&CondExE&!StallE.
REQ-020 SHALL load FlagsE[1:0] from ALUFlags[1:0] on a clock edge when FlagWriteE[0]&CondExE&!StallE.
REQ-021 SHALL evaluate the condition of an instruction using flags written by the immediately preceding instruction, with no extra bubble.
REQ-022 SHALL update flags on a clock edge with FlushE=1 according to the instruction leaving E; the flush affects only the incoming register contents.

Reset
REQ-023 SHALL, while reset=1 and independent of clk, clear all E-stage control registers and CondE to 0 and set FlagsE=FLAGS_RST.
REQ-024 SHALL hold all gated outputs at 0 during reset and SHALL resume normal capture on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL, when COND_EXEC_EN is defined, implement REQ-016 as written.
REQ-026 SHALL, when COND_EXEC_EN is not defined, tie CondExE=1 and ignore CondD; flag updates and gating still follow REQ-017 to REQ-020 with CondExE=1.

Verification
REQ-027 Reset: assert reset mid-cycle with RegWriteE=1 -> outputs 0 immediately, FlagsE=0000.
REQ-028 Predicated skip: flags Z=1, CondD=0001 (NE), RegWriteD=1, MemWriteD=1 -> next cycle CondExE=0, RegWriteGE=0, MemWriteGE=0.
REQ-029 CMP followed by a branch:
- Cycle 1: FlagWriteD=11, NoWriteD=1, CondD=1110; ALUFlags=0100 during E.
- Cycle 2: CondD=0000, BranchD=1, PCSrcD=1 -> BranchTakenE=1, PCSrcGE=1, RegWriteGE=0 in cycle 1.
REQ-030 Stall then flush: StallE=1 for 2 cycles holds ALUControlE=010 and FlagsE; StallE=1 with FlushE=1 -> all E controls 0 next cycle.
REQ-031 Partial flag write: FlagsE=1111, FlagWriteE=10, ALUFlags=0000 -> FlagsE=0011.
REQ-032 Condition decode: GT/LE with N=1, V=0, Z=0 -> GT=0, LE=1; CondD=1111 -> CondExE=0 (or 1 without COND_EXEC_EN).
